// File: rtl/pipe_ctrl_unit_if.sv
// Bus between the pipeline control unit and its datapath: ID-stage inputs
// and the staged EX/MEM/WB controls, hazard stall and status outputs.
interface pipe_ctrl_unit_if #(
    parameter int ALUOP_W = 3,
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 16
);
    logic [5:0]         instr_op_i;
    logic [REG_AW-1:0]  id_rs_i;
    logic [REG_AW-1:0]  id_rt_i;
    logic               flush_i;
    logic               ex_regdst_o;
    logic               ex_alusrc_o;
    logic [ALUOP_W-1:0] ex_aluop_o;
    logic               ex_branch_o;
    logic               ex_jump_o;
    logic               mem_memread_o;
    logic               mem_memwrite_o;
    logic               wb_regwrite_o;
    logic               wb_memtoreg_o;
    logic               stall_o;
    logic               illegal_o;
    logic [CNT_W-1:0]   stall_cnt_o;

    modport master (
        output instr_op_i, id_rs_i, id_rt_i, flush_i,
        input  ex_regdst_o, ex_alusrc_o, ex_aluop_o, ex_branch_o, ex_jump_o,
               mem_memread_o, mem_memwrite_o, wb_regwrite_o, wb_memtoreg_o,
               stall_o, illegal_o, stall_cnt_o
    );

    modport slave (
        input  instr_op_i, id_rs_i, id_rt_i, flush_i,
        output ex_regdst_o, ex_alusrc_o, ex_aluop_o, ex_branch_o, ex_jump_o,
               mem_memread_o, mem_memwrite_o, wb_regwrite_o, wb_memtoreg_o,
               stall_o, illegal_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipelined main-control decoder: ID-stage opcode decode, EX/MEM/WB control
// registers, load-use stall detection, sticky illegal flag and stall counter.
module pipe_ctrl_unit #(
    parameter int ALUOP_W   = 3,
    parameter int REG_AW    = 5,
    parameter int HAZARD_EN = 1,
    parameter int CNT_W     = 16
) (
    input logic              clk_i,
    input logic              rst_i,
    pipe_ctrl_unit_if.slave  bus
);
    typedef enum logic [5:0] {
        OP_RTYPE = 6'd0,  OP_BGEZ = 6'd1,  OP_J    = 6'd2,  OP_BEQ  = 6'd4,
        OP_BNE   = 6'd5,  OP_BGT  = 6'd7,  OP_ADDI = 6'd8,  OP_SLTI = 6'd10,
        OP_ORI   = 6'd13, OP_LUI  = 6'd15, OP_NOP  = 6'd32, OP_LW   = 6'd35,
        OP_SW    = 6'd43
    } opcode_e;

    typedef struct packed {
        logic               regDst;
        logic               aluSrc;
        logic [ALUOP_W-1:0] aluOp;
        logic               branch;
        logic               jump;
        logic               memRead;
        logic               memWrite;
        logic               regWrite;
        logic               memToReg;
    } ctrl_t;

    ctrl_t             dec, exC;
    logic              legal, loadUse, stall, kill;
    logic [REG_AW-1:0] exRt;
    logic              memRead, memWrite, memRegWrite, memMemToReg;
    logic              wbRegWrite, wbMemToReg;
    logic              illegal;
    logic [CNT_W-1:0]  stallCnt;

    always_comb begin
        dec   = '0;
        legal = 1'b1;
        case (bus.instr_op_i)
            OP_RTYPE: begin dec.aluOp = ALUOP_W'(2); dec.regWrite = 1'b1; dec.regDst = 1'b1; end
            OP_ADDI:  begin dec.aluOp = ALUOP_W'(0); dec.regWrite = 1'b1; dec.aluSrc = 1'b1; end
            OP_SLTI:  begin dec.aluOp = ALUOP_W'(2); dec.regWrite = 1'b1; dec.aluSrc = 1'b1; end
            OP_ORI:   begin dec.aluOp = ALUOP_W'(4); dec.regWrite = 1'b1; dec.aluSrc = 1'b1; end
            OP_LUI:   begin dec.aluOp = ALUOP_W'(3); dec.regWrite = 1'b1; dec.aluSrc = 1'b1; end
            OP_LW: begin
                dec.aluOp    = ALUOP_W'(0);
                dec.regWrite = 1'b1;
                dec.aluSrc   = 1'b1;
                dec.memRead  = 1'b1;
                dec.memToReg = 1'b1;
            end
            OP_SW:    begin dec.aluOp = ALUOP_W'(0); dec.aluSrc = 1'b1; dec.memWrite = 1'b1; end
            OP_BEQ:   begin dec.aluOp = ALUOP_W'(1); dec.branch = 1'b1; end
            OP_BNE:   begin dec.aluOp = ALUOP_W'(5); dec.branch = 1'b1; end
            OP_BGT:   begin dec.aluOp = ALUOP_W'(6); dec.branch = 1'b1; end
            OP_BGEZ:  begin dec.aluOp = ALUOP_W'(7); dec.branch = 1'b1; end
            OP_J:     dec.jump = 1'b1;
            OP_NOP:   dec = '0;
            default:  legal = 1'b0;
        endcase
    end

    // A load in EX whose destination feeds the ID instruction must slip one cycle;
    // a flush kills the ID instruction anyway, so it overrides the stall.
    always_comb begin
        loadUse = (HAZARD_EN != 0) && exC.memRead && (exRt != '0) &&
                  ((exRt == bus.id_rs_i) || (exRt == bus.id_rt_i));
        stall   = loadUse && !bus.flush_i;
        kill    = bus.flush_i || stall;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            exC         <= '0;
            exRt        <= '0;
            memRead     <= 1'b0;
            memWrite    <= 1'b0;
            memRegWrite <= 1'b0;
            memMemToReg <= 1'b0;
            wbRegWrite  <= 1'b0;
            wbMemToReg  <= 1'b0;
            illegal     <= 1'b0;
            stallCnt    <= '0;
        end else begin
            exC         <= kill ? '0 : dec;
            exRt        <= bus.id_rt_i;
            memRead     <= exC.memRead;
            memWrite    <= exC.memWrite;
            memRegWrite <= exC.regWrite;
            memMemToReg <= exC.memToReg;
            wbRegWrite  <= memRegWrite;
            wbMemToReg  <= memMemToReg;
            if (!legal && !kill)
                illegal <= 1'b1;
            if (stall && (stallCnt != '1))
                stallCnt <= stallCnt + 1'b1;
        end
    end

    assign bus.ex_regdst_o    = exC.regDst;
    assign bus.ex_alusrc_o    = exC.aluSrc;
    assign bus.ex_aluop_o     = exC.aluOp;
    assign bus.ex_branch_o    = exC.branch;
    assign bus.ex_jump_o      = exC.jump;
    assign bus.mem_memread_o  = memRead;
    assign bus.mem_memwrite_o = memWrite;
    assign bus.wb_regwrite_o  = wbRegWrite;
    assign bus.wb_memtoreg_o  = wbMemToReg;
    assign bus.stall_o        = stall;
    assign bus.illegal_o      = illegal;
    assign bus.stall_cnt_o    = stallCnt;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Randomized bench for pipe_ctrl_unit: an issue-history model predicts every
// stage output each cycle; directed scenarios pin the model with literals.
module tb_pipe_ctrl_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_ctrl_unit_if #(.ALUOP_W(3), .REG_AW(5), .CNT_W(16)) bus16 ();
    pipe_ctrl_unit_if #(.ALUOP_W(3), .REG_AW(5), .CNT_W(2))  bus2 ();

    pipe_ctrl_unit #(.ALUOP_W(3), .REG_AW(5), .HAZARD_EN(1), .CNT_W(16)) dut16 (
        .clk_i(clk), .rst_i(rst), .bus(bus16.slave));
    pipe_ctrl_unit #(.ALUOP_W(3), .REG_AW(5), .HAZARD_EN(1), .CNT_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .bus(bus2.slave));

    assign bus2.instr_op_i = bus16.instr_op_i;
    assign bus2.id_rs_i    = bus16.id_rs_i;
    assign bus2.id_rt_i    = bus16.id_rt_i;
    assign bus2.flush_i    = bus16.flush_i;

    int nChecks = 0;
    int nPass   = 0;

    // control word: [10]regDst [9]aluSrc [8:6]aluOp [5]branch [4]jump
    //               [3]memRead [2]memWrite [1]regWrite [0]memToReg
    logic [10:0] ctab [int];
    logic [10:0] hist [$];
    int mRt, mCnt16, mCnt2;
    logic mIllegal;
    logic dStall;

    function automatic logic [10:0] cw(bit rd, bit as, int op, bit br, bit j,
                                       bit mr, bit mw, bit rw, bit m2r);
        logic [2:0] a = op[2:0];
        return {rd, as, a, br, j, mr, mw, rw, m2r};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] allOut16();
        return {bus16.ex_regdst_o, bus16.ex_alusrc_o, bus16.ex_aluop_o, bus16.ex_branch_o,
                bus16.ex_jump_o, bus16.mem_memread_o, bus16.mem_memwrite_o,
                bus16.wb_regwrite_o, bus16.wb_memtoreg_o, bus16.stall_o,
                bus16.illegal_o, bus16.stall_cnt_o};
    endfunction

    function automatic logic [31:0] allOut2();
        return {bus2.ex_regdst_o, bus2.ex_alusrc_o, bus2.ex_aluop_o, bus2.ex_branch_o,
                bus2.ex_jump_o, bus2.mem_memread_o, bus2.mem_memwrite_o,
                bus2.wb_regwrite_o, bus2.wb_memtoreg_o, bus2.stall_o,
                bus2.illegal_o, bus2.stall_cnt_o};
    endfunction

    function automatic logic [6:0] exOut();
        return {bus16.ex_regdst_o, bus16.ex_alusrc_o, bus16.ex_aluop_o,
                bus16.ex_branch_o, bus16.ex_jump_o};
    endfunction

    task automatic modelReset();
        hist = '{11'd0, 11'd0, 11'd0};
        mRt = 0; mCnt16 = 0; mCnt2 = 0; mIllegal = 1'b0;
    endtask

    // One cycle: drive just after the edge, compare mid-cycle, advance model on the edge.
    task automatic step(int op, int rs, int rt, bit fl);
        bit legal, expStall;
        logic [10:0] issued;
        bus16.instr_op_i = op[5:0];
        bus16.id_rs_i    = rs[4:0];
        bus16.id_rt_i    = rt[4:0];
        bus16.flush_i    = fl;
        @(negedge clk);
        expStall = hist[0][3] && (mRt != 0) && (mRt == rs || mRt == rt) && !fl;
        chk("ex",      {25'd0, exOut()}, {25'd0, hist[0][10:4]});
        chk("mem",     {30'd0, bus16.mem_memread_o, bus16.mem_memwrite_o}, {30'd0, hist[1][3:2]});
        chk("wb",      {30'd0, bus16.wb_regwrite_o, bus16.wb_memtoreg_o}, {30'd0, hist[2][1:0]});
        chk("stall",   {31'd0, bus16.stall_o}, {31'd0, expStall});
        chk("illegal", {31'd0, bus16.illegal_o}, {31'd0, mIllegal});
        chk("cnt16",   {16'd0, bus16.stall_cnt_o}, mCnt16);
        chk("cnt2",    {30'd0, bus2.stall_cnt_o}, mCnt2);
        chk("stall2",  {31'd0, bus2.stall_o}, {31'd0, expStall});
        dStall = bus16.stall_o;
        @(posedge clk);
        legal  = ctab.exists(op);
        issued = (fl || expStall || !legal) ? 11'd0 : ctab[op];
        if (!legal && !fl && !expStall) mIllegal = 1'b1;
        if (expStall) begin
            if (mCnt16 < 65535) mCnt16++;
            if (mCnt2 < 3) mCnt2++;
        end
        hist.push_front(issued);
        void'(hist.pop_back());
        mRt = rt;
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        #1;
        chk("rst all16", allOut16(), 32'd0);
        chk("rst all2",  allOut2(),  32'd0);
        modelReset();
        #2;
        rst = 1'b0;
    endtask

    int ops [$] = '{0, 8, 10, 13, 15, 35, 43, 4, 5, 7, 1, 2, 32, 35, 35, 63, 17, 50};

    initial begin
        ctab[0]  = cw(1, 0, 2, 0, 0, 0, 0, 1, 0);
        ctab[8]  = cw(0, 1, 0, 0, 0, 0, 0, 1, 0);
        ctab[10] = cw(0, 1, 2, 0, 0, 0, 0, 1, 0);
        ctab[13] = cw(0, 1, 4, 0, 0, 0, 0, 1, 0);
        ctab[15] = cw(0, 1, 3, 0, 0, 0, 0, 1, 0);
        ctab[35] = cw(0, 1, 0, 0, 0, 1, 0, 1, 1);
        ctab[43] = cw(0, 1, 0, 0, 0, 0, 1, 0, 0);
        ctab[4]  = cw(0, 0, 1, 1, 0, 0, 0, 0, 0);
        ctab[5]  = cw(0, 0, 5, 1, 0, 0, 0, 0, 0);
        ctab[7]  = cw(0, 0, 6, 1, 0, 0, 0, 0, 0);
        ctab[1]  = cw(0, 0, 7, 1, 0, 0, 0, 0, 0);
        ctab[2]  = cw(0, 0, 0, 0, 1, 0, 0, 0, 0);
        ctab[32] = cw(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus16.instr_op_i = 6'd32; bus16.id_rs_i = '0; bus16.id_rt_i = '0; bus16.flush_i = 1'b0;
        modelReset();
        @(posedge clk); #1;
        doReset();

        // load-use: one stall cycle, bubble in EX, R-type reaches EX two cycles after lw
        step(35, 0, 3, 0);
        step(0, 3, 0, 0);
        chk("r36 stall", {31'd0, dStall}, 32'd1);
        chk("r36 exBubble", {25'd0, exOut()}, 32'd0);
        chk("r36 cnt", {16'd0, bus16.stall_cnt_o}, 32'd1);
        step(0, 3, 0, 0);
        chk("r36 restall", {31'd0, dStall}, 32'd0);
        chk("r36 regdst", {31'd0, bus16.ex_regdst_o}, 32'd1);
        chk("r36 aluop", {29'd0, bus16.ex_aluop_o}, 32'd2);

        // flush overrides the stall
        doReset();
        step(35, 0, 3, 0);
        step(0, 3, 0, 1);
        chk("r37 stall", {31'd0, dStall}, 32'd0);
        chk("r37 exBubble", {25'd0, exOut()}, 32'd0);
        chk("r37 cnt", {16'd0, bus16.stall_cnt_o}, 32'd0);

        // $zero destination never stalls
        doReset();
        step(35, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("r38 stall", {31'd0, dStall}, 32'd0);
        chk("r38 regdst", {31'd0, bus16.ex_regdst_o}, 32'd1);

        // sw through the stages
        doReset();
        step(43, 0, 0, 0);
        chk("r39 alusrc", {31'd0, bus16.ex_alusrc_o}, 32'd1);
        step(32, 0, 0, 0);
        chk("r39 memwrite", {31'd0, bus16.mem_memwrite_o}, 32'd1);
        step(32, 0, 0, 0);
        chk("r39 regwrite", {31'd0, bus16.wb_regwrite_o}, 32'd0);

        // illegal opcode is sticky; the next instruction still decodes
        doReset();
        step(63, 0, 0, 0);
        chk("r40 illegal", {31'd0, bus16.illegal_o}, 32'd1);
        chk("r40 exZero", {25'd0, exOut()}, 32'd0);
        step(8, 0, 0, 0);
        chk("r40 addi", {25'd0, exOut()}, 32'h20);
        chk("r40 sticky", {31'd0, bus16.illegal_o}, 32'd1);

        // five load-use pairs saturate the 2-bit counter
        doReset();
        for (int i = 0; i < 5; i++) begin
            step(35, 0, 1, 0);
            step(0, 1, 0, 0);
            step(0, 1, 0, 0);
        end
        chk("r41 cnt2", {30'd0, bus2.stall_cnt_o}, 32'd3);
        chk("r41 cnt16", {16'd0, bus16.stall_cnt_o}, 32'd5);
        step(35, 0, 2, 0);
        step(43, 0, 0, 0);
        doReset();

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) doReset();
            step(ops[$urandom_range(0, ops.size() - 1)], $urandom_range(0, 3),
                 $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
